// File: rtl/hazard_fwd_unit_pkg.sv
// Shared forwarding-select encodings and the shadow pipeline stage record.
// Record dest is held at a fixed width; narrower specifiers are zero-extended into it.
package hazard_fwd_unit_pkg;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXMM = 2'b01;
   localparam logic [1:0] FWD_MMWB = 2'b10;

   localparam int REC_DEST_W = 8;

   typedef struct packed {
      logic                  valid;
      logic [REC_DEST_W-1:0] dest;
      logic                  regwrite;
      logic                  memread;
   } stage_rec_t;

   function automatic stage_rec_t bubble_rec();
      stage_rec_t r;
      r = '0;
      return r;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source specifier against one stage record; purely combinational.
// Register 0 never matches, so it can never forward or stall.
module hazard_match
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_src,
   input  logic              i_used,
   input  stage_rec_t        i_rec,
   output logic              o_hit,
   output logic              o_is_load
);

   logic [REC_DEST_W-1:0] w_src_ext;
   logic                  w_src_nonzero;

   assign w_src_ext     = REC_DEST_W'(i_src);
   assign w_src_nonzero = (i_src != '0);

   assign o_hit = i_used && i_rec.valid && i_rec.regwrite &&
                  (i_rec.dest == w_src_ext) && w_src_nonzero;

   assign o_is_load = o_hit && i_rec.memread;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection / forwarding control: stall_id is combinational, controls and bubble_ex are registered.
// HAZARD_FWD_EN defined enables EX/MM and MM/WB forwarding; undefined stalls until the producer reaches WB.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_id,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic              uses_rs_id,
   input  logic              uses_rt_id,
   input  logic [REG_AW-1:0] dest_id,
   input  logic              regwrite_id,
   input  logic              memread_id,
   output logic [1:0]        Forwarding_control_1,
   output logic [1:0]        Forwarding_control_2,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic [CNT_W-1:0]  stall_count
);

   stage_rec_t r_ex;
   stage_rec_t r_mm;
   stage_rec_t r_wb;
   stage_rec_t w_id_rec;

   logic             r_bubble;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_used_rs;
   logic w_used_rt;
   logic w_rs_ex_hit, w_rs_ex_load;
   logic w_rt_ex_hit, w_rt_ex_load;
   logic w_rs_mm_hit, w_rs_mm_load;
   logic w_rt_mm_hit, w_rt_mm_load;
   logic w_hazard;
   logic w_stall;

   assign w_used_rs = valid_id & uses_rs_id;
   assign w_used_rt = valid_id & uses_rt_id;

   always_comb begin
      w_id_rec          = bubble_rec();
      w_id_rec.valid    = valid_id;
      w_id_rec.dest     = REC_DEST_W'(dest_id);
      w_id_rec.regwrite = regwrite_id;
      w_id_rec.memread  = memread_id;
   end

   hazard_match #(.REG_AW(REG_AW)) u_rs_ex (
      .i_src     (rs_id),
      .i_used    (w_used_rs),
      .i_rec     (r_ex),
      .o_hit     (w_rs_ex_hit),
      .o_is_load (w_rs_ex_load)
   );

   hazard_match #(.REG_AW(REG_AW)) u_rt_ex (
      .i_src     (rt_id),
      .i_used    (w_used_rt),
      .i_rec     (r_ex),
      .o_hit     (w_rt_ex_hit),
      .o_is_load (w_rt_ex_load)
   );

   hazard_match #(.REG_AW(REG_AW)) u_rs_mm (
      .i_src     (rs_id),
      .i_used    (w_used_rs),
      .i_rec     (r_mm),
      .o_hit     (w_rs_mm_hit),
      .o_is_load (w_rs_mm_load)
   );

   hazard_match #(.REG_AW(REG_AW)) u_rt_mm (
      .i_src     (rt_id),
      .i_used    (w_used_rt),
      .i_rec     (r_mm),
      .o_hit     (w_rt_mm_hit),
      .o_is_load (w_rt_mm_load)
   );

`ifdef HAZARD_FWD_EN
   // Only a load still in EX cannot be covered by forwarding.
   assign w_hazard = w_rs_ex_load | w_rt_ex_load;
`else
   // WB needs no stall: the register file writes before it is read.
   assign w_hazard = w_rs_ex_hit | w_rt_ex_hit | w_rs_mm_hit | w_rt_mm_hit;
`endif

   assign w_stall  = valid_id & w_hazard;
   assign stall_id = w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex <= bubble_rec();
         r_mm <= bubble_rec();
         r_wb <= bubble_rec();
      end else begin
         r_ex <= w_stall ? bubble_rec() : w_id_rec;
         r_mm <= r_ex;
         r_wb <= r_mm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_bubble <= w_stall;
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bubble_ex   = r_bubble;
   assign stall_count = r_stall_cnt;

`ifdef HAZARD_FWD_EN
   logic [1:0] w_fwd1_nxt;
   logic [1:0] w_fwd2_nxt;
   logic [1:0] r_fwd1;
   logic [1:0] r_fwd2;

   // The producer one stage ahead moves to MM as the consumer enters EX, hence EX match -> EX/MM.
   always_comb begin
      w_fwd1_nxt = FWD_RF;
      w_fwd2_nxt = FWD_RF;
      if (w_rs_ex_hit) begin
         w_fwd1_nxt = FWD_EXMM;
      end else if (w_rs_mm_hit) begin
         w_fwd1_nxt = FWD_MMWB;
      end
      if (w_rt_ex_hit) begin
         w_fwd2_nxt = FWD_EXMM;
      end else if (w_rt_mm_hit) begin
         w_fwd2_nxt = FWD_MMWB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd1 <= FWD_RF;
         r_fwd2 <= FWD_RF;
      end else if (w_stall) begin
         r_fwd1 <= FWD_RF;
         r_fwd2 <= FWD_RF;
      end else begin
         r_fwd1 <= w_fwd1_nxt;
         r_fwd2 <= w_fwd2_nxt;
      end
   end

   assign Forwarding_control_1 = r_fwd1;
   assign Forwarding_control_2 = r_fwd2;
`else
   assign Forwarding_control_1 = FWD_RF;
   assign Forwarding_control_2 = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and random stimulus for hazard_fwd_unit against an instruction-level pipeline model.
module tb_hazard_fwd_unit;

   localparam int AW   = 5;
   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_id;
   logic [AW-1:0] rs_id;
   logic [AW-1:0] rt_id;
   logic          uses_rs_id;
   logic          uses_rt_id;
   logic [AW-1:0] dest_id;
   logic          regwrite_id;
   logic          memread_id;
   logic [1:0]    Forwarding_control_1;
   logic [1:0]    Forwarding_control_2;
   logic          stall_id;
   logic          bubble_ex;
   logic [CW-1:0] stall_count;

   hazard_fwd_unit #(.REG_AW(AW), .CNT_W(CW)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .valid_id             (valid_id),
      .rs_id                (rs_id),
      .rt_id                (rt_id),
      .uses_rs_id           (uses_rs_id),
      .uses_rt_id           (uses_rt_id),
      .dest_id              (dest_id),
      .regwrite_id          (regwrite_id),
      .memread_id           (memread_id),
      .Forwarding_control_1 (Forwarding_control_1),
      .Forwarding_control_2 (Forwarding_control_2),
      .stall_id             (stall_id),
      .bubble_ex            (bubble_ex),
      .stall_count          (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int rs;
      int rt;
      bit urs;
      bit urt;
      int d;
      bit rw;
      bit mr;
   } ins_t;

   // Instructions currently in EX and MM, as the model sees them.
   ins_t m_ex;
   ins_t m_mm;
   int   m_cnt;
   int   m_f1;
   int   m_f2;
   bit   m_bub;

   int checks = 0;
   int errors = 0;

   function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int d, bit rw, bit mr);
      ins_t i;
      i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
      i.d = d; i.rw = rw; i.mr = mr;
      return i;
   endfunction

   function automatic bit writes(ins_t p, int r);
      return p.v && p.rw && (p.d == r) && (r != 0);
   endfunction

   function automatic int fwd_sel(ins_t i, bit used, int r);
`ifdef HAZARD_FWD_EN
      if (!i.v || !used) return 0;
      if (writes(m_ex, r)) return 1;
      if (writes(m_mm, r)) return 2;
      return 0;
`else
      return 0;
`endif
   endfunction

   function automatic bit src_hazard(bit used, int r);
      if (!used) return 1'b0;
`ifdef HAZARD_FWD_EN
      return writes(m_ex, r) && m_ex.mr;
`else
      return writes(m_ex, r) || writes(m_mm, r);
`endif
   endfunction

   function automatic bit model_stall(ins_t i);
      if (!i.v) return 1'b0;
      return src_hazard(i.urs, i.rs) || src_hazard(i.urt, i.rt);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ex  = mk(0, 0, 0, 0, 0, 0, 0, 0);
      m_mm  = m_ex;
      m_cnt = 0;
      m_f1  = 0;
      m_f2  = 0;
      m_bub = 1'b0;
   endtask

   task automatic model_edge(input ins_t i, input bit st);
      if (st) begin
         m_f1  = 0;
         m_f2  = 0;
         m_bub = 1'b1;
         if (m_cnt < CMAX) m_cnt++;
         m_mm  = m_ex;
         m_ex  = mk(0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
         m_f1  = fwd_sel(i, i.urs, i.rs);
         m_f2  = fwd_sel(i, i.urt, i.rt);
         m_bub = 1'b0;
         m_mm  = m_ex;
         m_ex  = i;
      end
   endtask

   task automatic drive(input ins_t i);
      valid_id    = i.v;
      rs_id       = AW'(i.rs);
      rt_id       = AW'(i.rt);
      uses_rs_id  = i.urs;
      uses_rt_id  = i.urt;
      dest_id     = AW'(i.d);
      regwrite_id = i.rw;
      memread_id  = i.mr;
   endtask

   task automatic check_regs();
      chk("fwd1", 32'(Forwarding_control_1), 32'(m_f1));
      chk("fwd2", 32'(Forwarding_control_2), 32'(m_f2));
      chk("bubble_ex", 32'(bubble_ex), 32'(m_bub));
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
   endtask

   task automatic step(input ins_t i, output bit st);
      @(negedge clk);
      drive(i);
      #1;
      st = model_stall(i);
      chk("stall_id", 32'(stall_id), 32'(st));
      @(posedge clk);
      model_edge(i, st);
      #1;
      check_regs();
   endtask

   // Re-presents a stalled instruction until the model lets it through.
   task automatic issue(input ins_t i);
      bit st;
      int n;
      n = 0;
      do begin
         step(i, st);
         n++;
      end while (st && n < 4);
   endtask

   initial begin
      ins_t nop;
      ins_t cons;
      int   c0;
      int   exp_d;
      bit   st;

      nop = mk(1, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      #1;
      chk("rst_stall", 32'(stall_id), 32'd0);
      chk("rst_bubble", 32'(bubble_ex), 32'd0);
      chk("rst_fwd1", 32'(Forwarding_control_1), 32'd0);
      chk("rst_fwd2", 32'(Forwarding_control_2), 32'd0);
      chk("rst_count", 32'(stall_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add $3 ; add $4,$3,$5
      c0 = m_cnt;
      issue(mk(1, 1, 2, 1, 1, 3, 1, 0));
      issue(mk(1, 3, 5, 1, 1, 4, 1, 0));
`ifdef HAZARD_FWD_EN
      exp_d = 0;
`else
      exp_d = 2;
`endif
      chk("raw_back2back_stalls", 32'(stall_count), 32'(c0 + exp_d));
      issue(nop);
      issue(nop);

      // add $3 ; nop ; sub $6,$7,$3
      issue(mk(1, 1, 2, 1, 1, 3, 1, 0));
      issue(nop);
      issue(mk(1, 7, 3, 1, 1, 6, 1, 0));
      issue(nop);
      issue(nop);

      // lw $3 ; add $4,$3,$3
      c0 = m_cnt;
      issue(mk(1, 1, 0, 1, 0, 3, 1, 1));
      issue(mk(1, 3, 3, 1, 1, 4, 1, 0));
`ifdef HAZARD_FWD_EN
      exp_d = 1;
`else
      exp_d = 2;
`endif
      chk("load_use_stalls", 32'(stall_count), 32'(c0 + exp_d));
      issue(nop);
      issue(nop);

      // add $0 ; add $4,$0,$0
      c0 = m_cnt;
      issue(mk(1, 1, 2, 1, 1, 0, 1, 0));
      issue(mk(1, 0, 0, 1, 1, 4, 1, 0));
      chk("reg0_no_stall", 32'(stall_count), 32'(c0));
      chk("reg0_fwd1", 32'(Forwarding_control_1), 32'd0);
      issue(nop);
      issue(nop);

      for (int k = 0; k < 400; k++) begin
         ins_t r;
         r.v   = ($urandom % 8) != 0;
         r.rs  = $urandom_range(0, 7);
         r.rt  = ($urandom % 4 == 0) ? r.rs : $urandom_range(0, 7);
         r.urs = $urandom % 2;
         r.urt = $urandom % 2;
         r.d   = $urandom_range(0, 7);
         r.rw  = ($urandom % 4) != 0;
         r.mr  = r.rw && (($urandom % 3) == 0);
         issue(r);
      end

      // Drive the counter into saturation with repeated load-use pairs.
      for (int k = 0; k < 40; k++) begin
         issue(mk(1, 1, 0, 1, 0, 5, 1, 1));
         issue(mk(1, 5, 5, 1, 1, 6, 1, 0));
      end
      chk("count_saturated", 32'(stall_count), 32'(CMAX));

      // Reset in the middle of a stall.
      issue(mk(1, 1, 0, 1, 0, 3, 1, 1));
      cons = mk(1, 3, 3, 1, 1, 4, 1, 0);
      @(negedge clk);
      drive(cons);
      #1;
      st = model_stall(cons);
      chk("pre_reset_stall", 32'(stall_id), 32'(st));
      chk("pre_reset_stall_hi", 32'(stall_id), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(stall_id), 32'd0);
      chk("mid_rst_bubble", 32'(bubble_ex), 32'd0);
      chk("mid_rst_fwd1", 32'(Forwarding_control_1), 32'd0);
      chk("mid_rst_fwd2", 32'(Forwarding_control_2), 32'd0);
      chk("mid_rst_count", 32'(stall_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      issue(cons);
      chk("post_rst_count", 32'(stall_count), 32'd0);
      chk("post_rst_fwd1", 32'(Forwarding_control_1), 32'd0);
      issue(nop);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
